// File: rtl/sdc_pgen_pkg.sv
// sdc_pgen_pkg: shared types, constants and helper functions for the
// sdc_test2 pattern generator (FSM states, LFSR/MISR constants, step functions).
package sdc_pgen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pgenState_t;

   localparam int          LFSR_W    = 8;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

   // An all-zero LFSR never leaves zero, so a zero seed is forced to 1.
   function automatic logic [LFSR_W-1:0] safeSeed(input logic [LFSR_W-1:0] seed);
      return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
   endfunction

   // Fibonacci step: shift left, feed back the parity of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsrStep(input logic [LFSR_W-1:0] lfsr);
      return {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
   endfunction

   // One MISR fold of a 2-bit response into the 16-bit signature.
   function automatic logic [15:0] misrStep(input logic [15:0] sig, input logic [1:0] data);
      return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, data};
   endfunction

endpackage

// File: rtl/sdc_pgen_misr.sv
// sdc_pgen_misr: 16-bit multiple-input signature register folding the 2-bit
// response of the logic cone. Clear wins over enable.
module sdc_pgen_misr
   import sdc_pgen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_enable,
   input  logic [1:0]  i_data,
   output logic [15:0] o_sig
);

   logic [15:0] r_sig;

   // Signature register: cleared on reset or run start, folds data when enabled.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_sig <= '0;
      end else if (i_enable) begin
         r_sig <= misrStep(r_sig, i_data);
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/sdc_pattern_gen.sv
// sdc_pattern_gen: clocked stimulus source and response sink for sdc_test2.
// An LFSR drives {in3,in2,in1}; responses {out2,out1} are folded into a MISR
// DRAIN_CYC cycles after each pattern is issued.
// Optional golden-signature compare is enabled with `define SDC_PGEN_COMPARE_EN.
// MISR_W must stay 16 because the feedback polynomial is fixed.
module sdc_pattern_gen
   import sdc_pgen_pkg::*;
#(
   parameter int         PAT_COUNT = 64,
   parameter logic [7:0] SEED      = 8'hA5,
   parameter int         DRAIN_CYC = 3,
   parameter int         MISR_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [2:0]                     pat_out,
   input  logic [1:0]                     resp_in,
   output logic [$clog2(PAT_COUNT+1)-1:0] pat_cnt,
   output logic [MISR_W-1:0]              signature
`ifdef SDC_PGEN_COMPARE_EN
   ,
   input  logic [MISR_W-1:0]              golden_sig,
   output logic                           pass
`endif
);

   localparam int CNT_W   = $clog2(PAT_COUNT+1);
   localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   pgenState_t             r_state;
   pgenState_t             w_stateNext;
   logic                   w_accept;
   logic                   w_issue;
   logic                   w_capture;
   logic [LFSR_W-1:0]      r_lfsr;
   logic [2:0]             r_patOut;
   logic [CNT_W-1:0]       r_patCnt;
   logic [DRAIN_W-1:0]     r_drainCnt;
   logic [DRAIN_CYC-1:0]   r_pipe;
   logic                   r_busy;
   logic                   r_done;
   logic [15:0]            w_sig;

   assign w_issue   = (r_state == RUN);
   assign w_capture = r_pipe[DRAIN_CYC-1];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic; start is only honoured from IDLE or DONE.
   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_stateNext = RUN;
               w_accept    = 1'b1;
            end
         end
         RUN: begin
            if (r_patCnt == CNT_W'(PAT_COUNT-1)) begin
               w_stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (r_drainCnt == DRAIN_W'(DRAIN_CYC-1)) begin
               w_stateNext = DONE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Pattern issue: LFSR, pattern register, counter and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr   <= safeSeed(SEED);
         r_patOut <= '0;
         r_patCnt <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy <= (w_stateNext == RUN) || (w_stateNext == DRAIN);
         r_done <= (w_stateNext == DONE);
         if (w_accept) begin
            r_lfsr   <= safeSeed(SEED);
            r_patOut <= '0;
            r_patCnt <= '0;
         end else if (w_issue) begin
            r_patOut <= r_lfsr[2:0];
            r_lfsr   <= lfsrStep(r_lfsr);
            r_patCnt <= r_patCnt + CNT_W'(1);
         end else begin
            r_patOut <= '0;
         end
      end
   end

   // Counts cycles spent in DRAIN so the run ends after DRAIN_CYC of them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drainCnt <= '0;
      end else if (r_state == DRAIN) begin
         r_drainCnt <= r_drainCnt + DRAIN_W'(1);
      end else begin
         r_drainCnt <= '0;
      end
   end

   // Capture pipe: each issued pattern's valid bit emerges DRAIN_CYC cycles later.
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_pipe <= '0;
      end else begin
         r_pipe <= (r_pipe << 1) | DRAIN_CYC'(w_issue);
      end
   end

   sdc_pgen_misr u_misr (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_accept),
      .i_enable (w_capture),
      .i_data   (resp_in),
      .o_sig    (w_sig)
   );

`ifdef SDC_PGEN_COMPARE_EN
   logic [15:0] w_sigFinal;

   // The last fold lands on the same edge done rises, so compare the post-fold value.
   assign w_sigFinal = w_capture ? misrStep(w_sig, resp_in) : w_sig;

   // Pass flag: evaluated once per run as it completes.
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         pass <= 1'b0;
      end else if ((r_state == DRAIN) && (w_stateNext == DONE)) begin
         pass <= (MISR_W'(w_sigFinal) == golden_sig);
      end
   end
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign pat_out   = r_patOut;
   assign pat_cnt   = r_patCnt;
   assign signature = MISR_W'(w_sig);

endmodule
